// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop command controller.
package sr_pkg;

   localparam int PULSE_LEN_DEF = 2;
   localparam int TIMEOUT_DEF   = 4;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } sr_state_t;

   // True when the flip-flop feedback already shows the requested level.
   function automatic logic fb_match(input logic q, input logic qb, input logic level);
      return (q == level) && (qb == ~level);
   endfunction

endpackage

// File: rtl/sr_ctrl_if.sv
// Command handshake, flip-flop drive/feedback and status bundle for sr_ctrl.
// Handshake: a command transfers on a rising edge where req_valid and
// req_ready are both 1; req_level is sampled on that same edge. req_valid
// while req_ready is 0 is dropped, nothing is queued.
interface sr_ctrl_if;

   logic req_valid;
   logic req_level;
   logic req_ready;
   logic q_fb;
   logic qb_fb;
   logic clr_err;
   logic s;
   logic r;
   logic done;
   logic err_timeout;
   logic err_fb;

   modport master (
      output req_valid, req_level, q_fb, qb_fb, clr_err,
      input  req_ready, s, r, done, err_timeout, err_fb
   );

   modport slave (
      input  req_valid, req_level, q_fb, qb_fb, clr_err,
      output req_ready, s, r, done, err_timeout, err_fb
   );

endinterface

// File: rtl/sr_ctrl.sv
// Drives an external SR flip-flop to a requested level with a fixed-length
// S or R pulse, then waits a bounded time for Q/QB feedback to confirm.
// Every output is a flop loaded from the next-state decode, so s and r can
// never glitch and never both be high.
module sr_ctrl
   import sr_pkg::*;
#(
   parameter int PULSE_LEN = PULSE_LEN_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic      clk,
   input  logic      rst,
   sr_ctrl_if.slave  bus,
   output sr_state_t state
);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

   sr_state_t        state_q, state_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             s_q, r_q, done_q, ready_q;
   logic             s_d, r_d, done_d, ready_d;
   logic             err_tmo_q, err_fb_q;
   logic             tmo_set, fb_set;

   // Next-state, counters and the values the output flops will load.
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      pulse_cnt_d = pulse_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      tmo_set     = 1'b0;
      fb_set      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && ready_q) begin
               level_d = bus.req_level;
               if (fb_match(bus.q_fb, bus.qb_fb, bus.req_level)) begin
                  state_d = DONE;
               end else begin
                  state_d     = DRIVE;
                  pulse_cnt_d = '0;
               end
            end
         end
         DRIVE: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               state_d    = WAIT;
               wait_cnt_d = '0;
            end else begin
               pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            // Q equal to QB is an illegal flip-flop state; flag it but keep waiting.
            if (bus.q_fb == bus.qb_fb) begin
               fb_set = 1'b1;
            end
            if (fb_match(bus.q_fb, bus.qb_fb, level_q)) begin
               state_d = DONE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = IDLE;
               tmo_set = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      s_d     = (state_d == DRIVE) && level_d;
      r_d     = (state_d == DRIVE) && !level_d;
      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   // State, captured level, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         level_q     <= 1'b0;
         pulse_cnt_q <= '0;
         wait_cnt_q  <= '0;
         s_q         <= 1'b0;
         r_q         <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         pulse_cnt_q <= pulse_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         s_q         <= s_d;
         r_q         <= r_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_tmo_q <= 1'b0;
         err_fb_q  <= 1'b0;
      end else begin
         err_tmo_q <= tmo_set | (err_tmo_q & ~bus.clr_err);
         err_fb_q  <= fb_set  | (err_fb_q  & ~bus.clr_err);
      end
   end

   assign bus.s           = s_q;
   assign bus.r           = r_q;
   assign bus.done        = done_q;
   assign bus.req_ready   = ready_q;
   assign bus.err_timeout = err_tmo_q;
   assign bus.err_fb      = err_fb_q;
   assign state           = state_q;

endmodule

// File: tb/tb_sr_ctrl.sv
// Bench for sr_ctrl: default-parameter instance for directed scenarios and a
// PULSE_LEN=1/TIMEOUT=1 instance for random commands. Each instance drives a
// behavioural SR flip-flop whose Q/QB can be overridden to inject faults.
module tb_sr_ctrl;
   import sr_pkg::*;

   localparam logic [1:0] OUT_DONE = 2'd1;
   localparam logic [1:0] OUT_TMO  = 2'd2;

   logic      clk = 1'b0;
   logic      rst;
   sr_state_t state_a, state_b;

   sr_ctrl_if ifa ();
   sr_ctrl_if ifb ();

   sr_ctrl dut_a (
      .clk   (clk),
      .rst   (rst),
      .bus   (ifa),
      .state (state_a)
   );

   sr_ctrl #(.PULSE_LEN(1), .TIMEOUT(1)) dut_b (
      .clk   (clk),
      .rst   (rst),
      .bus   (ifb),
      .state (state_b)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard state
   int         vectors     = 0;
   int         miscompares = 0;
   logic [1:0] exp_a_q[$];
   logic [1:0] exp_b_q[$];
   int         done_cnt_b  = 0;
   int         exp_ok_b    = 0;
   int         sr_viol     = 0;
   logic       tmo_prev_a  = 1'b0;
   logic       tmo_prev_b  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // SR flip-flop feedback models. mode 0 = real Q/QB, 1 = stuck Q=0/QB=1, 2 = Q=QB=1.
   logic       q_a, q_b;
   logic [1:0] mode_a, mode_b;

   function automatic logic [1:0] fb_out(input logic q, input logic [1:0] mode);
      case (mode)
         2'd1:    return 2'b01;
         2'd2:    return 2'b11;
         default: return {q, ~q};
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) q_a <= 1'b0;
      else if (ifa.s) q_a <= 1'b1;
      else if (ifa.r) q_a <= 1'b0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) q_b <= 1'b0;
      else if (ifb.s) q_b <= 1'b1;
      else if (ifb.r) q_b <= 1'b0;
   end

   logic [1:0] fb_a, fb_b;
   assign fb_a      = fb_out(q_a, mode_a);
   assign fb_b      = fb_out(q_b, mode_b);
   assign ifa.q_fb  = fb_a[1];
   assign ifa.qb_fb = fb_a[0];
   assign ifb.q_fb  = fb_b[1];
   assign ifb.qb_fb = fb_b[0];

   // output monitor for instance A: pops the expected outcome on done or a new timeout
   always @(negedge clk) begin
      if (!rst) begin
         if (ifa.done) begin
            if (exp_a_q.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
            else check("a_outcome", 32'(OUT_DONE), 32'(exp_a_q.pop_front()));
         end
         if (ifa.err_timeout && !tmo_prev_a) begin
            if (exp_a_q.size() == 0) check("a_unexpected_tmo", 32'd1, 32'd0);
            else check("a_outcome", 32'(OUT_TMO), 32'(exp_a_q.pop_front()));
         end
      end
      if (ifa.s && ifa.r) sr_viol++;
      tmo_prev_a = ifa.err_timeout;
   end

   // output monitor for instance B
   always @(negedge clk) begin
      if (!rst) begin
         if (ifb.done) begin
            done_cnt_b++;
            if (exp_b_q.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
            else check("b_outcome", 32'(OUT_DONE), 32'(exp_b_q.pop_front()));
         end
         if (ifb.err_timeout && !tmo_prev_b) begin
            if (exp_b_q.size() == 0) check("b_unexpected_tmo", 32'd1, 32'd0);
            else check("b_outcome", 32'(OUT_TMO), 32'(exp_b_q.pop_front()));
         end
      end
      if (ifb.s && ifb.r) sr_viol++;
      tmo_prev_b = ifb.err_timeout;
   end

   // Issue one command on instance A from a falling edge and follow it back to idle.
   // exp_done_at: falling edge (1 = first after accept) where done is expected, 0 = timeout.
   // poke: keep req_valid high with the opposite level while busy; it must be ignored.
   task automatic cmd_a(input logic level, input int exp_pulse, input int exp_done_at,
                        input logic poke);
      int   pulses  = 0;
      int   wrong   = 0;
      int   done_at = 0;
      logic ret     = 1'b0;
      exp_a_q.push_back((exp_done_at != 0) ? OUT_DONE : OUT_TMO);
      ifa.req_valid = 1'b1;
      ifa.req_level = level;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            if (poke) ifa.req_level = ~level;
            else ifa.req_valid = 1'b0;
         end
         if (poke && i == 3) ifa.req_valid = 1'b0;
         if (level ? ifa.s : ifa.r) pulses++;
         if (level ? ifa.r : ifa.s) wrong++;
         if (ifa.done && done_at == 0) done_at = i;
         if (ifa.req_ready) begin
            ret = 1'b1;
            break;
         end
      end
      ifa.req_valid = 1'b0;
      check("a_back_to_idle", 32'(ret), 32'd1);
      check("a_pulse_len", 32'(pulses), 32'(exp_pulse));
      check("a_wrong_drive", 32'(wrong), 32'd0);
      check("a_done_at", 32'(done_at), 32'(exp_done_at));
   endtask

   task automatic clear_a();
      ifa.clr_err = 1'b1;
      @(negedge clk);
      ifa.clr_err = 1'b0;
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       level;
      logic [1:0] fb;
      logic       ret;
      rst = 1'b1;
      ifa.req_valid = 1'b0; ifa.req_level = 1'b0; ifa.clr_err = 1'b0;
      ifb.req_valid = 1'b0; ifb.req_level = 1'b0; ifb.clr_err = 1'b0;
      mode_a = 2'd0; mode_b = 2'd0;
      repeat (2) @(negedge clk);

      // reset values
      check("rst_ready", 32'(ifa.req_ready), 32'd1);
      check("rst_s", 32'(ifa.s), 32'd0);
      check("rst_r", 32'(ifa.r), 32'd0);
      check("rst_done", 32'(ifa.done), 32'd0);
      check("rst_err_tmo", 32'(ifa.err_timeout), 32'd0);
      check("rst_err_fb", 32'(ifa.err_fb), 32'd0);
      check("rst_state", 32'(state_a), 32'(IDLE));

      // set command accepted on the first edge after release
      rst = 1'b0;
      cmd_a(1'b1, 2, 4, 1'b0);
      check("set_err_tmo", 32'(ifa.err_timeout), 32'd0);
      check("set_err_fb", 32'(ifa.err_fb), 32'd0);

      // already at target: no pulse, done right after accept
      cmd_a(1'b1, 0, 1, 1'b0);

      // reset command with ignored requests while busy
      cmd_a(1'b0, 2, 4, 1'b1);
      @(negedge clk);
      check("poke_ignored_s", 32'(ifa.s), 32'd0);
      check("poke_ignored_ready", 32'(ifa.req_ready), 32'd1);

      // timeout: Q stuck low
      mode_a = 2'd1;
      cmd_a(1'b1, 2, 0, 1'b0);
      check("tmo_flag", 32'(ifa.err_timeout), 32'd1);
      check("tmo_no_fb_err", 32'(ifa.err_fb), 32'd0);
      check("tmo_ready", 32'(ifa.req_ready), 32'd1);
      clear_a();
      check("tmo_cleared", 32'(ifa.err_timeout), 32'd0);

      // clr_err held through a new timeout: set wins
      ifa.clr_err = 1'b1;
      cmd_a(1'b1, 2, 0, 1'b0);
      check("set_wins_tmo", 32'(ifa.err_timeout), 32'd1);
      @(negedge clk);
      ifa.clr_err = 1'b0;
      check("set_wins_cleared", 32'(ifa.err_timeout), 32'd0);

      // feedback error: Q=QB=1 throughout the wait
      mode_a = 2'd2;
      cmd_a(1'b0, 2, 0, 1'b0);
      check("fb_err_flag", 32'(ifa.err_fb), 32'd1);
      mode_a = 2'd0;
      cmd_a(1'b1, 2, 4, 1'b0);
      check("fb_err_sticky", 32'(ifa.err_fb), 32'd1);
      clear_a();
      check("fb_err_cleared", 32'(ifa.err_fb), 32'd0);
      check("tmo_cleared_too", 32'(ifa.err_timeout), 32'd0);

      // reset during the drive pulse
      ifa.req_valid = 1'b1;
      ifa.req_level = 1'b0;
      @(negedge clk);
      ifa.req_valid = 1'b0;
      check("mid_drive_r", 32'(ifa.r), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_r_drop", 32'(ifa.r), 32'd0);
      check("mid_rst_ready", 32'(ifa.req_ready), 32'd1);
      check("mid_rst_state", 32'(state_a), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_done", 32'(ifa.done), 32'd0);
         check("post_rst_ready", 32'(ifa.req_ready), 32'd1);
      end
      cmd_a(1'b1, 2, 4, 1'b0);

      // random commands on the short-pulse instance
      for (int n = 0; n < 60; n++) begin
         level  = 1'($urandom_range(0, 1));
         mode_b = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
         fb     = fb_out(q_b, mode_b);
         if ((fb[1] == level && fb[0] == ~level) || mode_b == 2'd0) begin
            exp_b_q.push_back(OUT_DONE);
            exp_ok_b++;
         end else begin
            exp_b_q.push_back(OUT_TMO);
         end
         ifb.req_valid = 1'b1;
         ifb.req_level = level;
         ret = 1'b0;
         for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) ifb.req_valid = 1'b0;
            if (ifb.req_ready) begin
               ret = 1'b1;
               break;
            end
         end
         ifb.req_valid = 1'b0;
         if (!ret) check("b_back_to_idle", 32'(ret), 32'd1);
         ifb.clr_err = 1'b1;
         @(negedge clk);
         ifb.clr_err = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (2) @(negedge clk);

      check("b_done_count", 32'(done_cnt_b), 32'(exp_ok_b));
      check("s_r_exclusive", 32'(sr_viol), 32'd0);
      check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
      check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
